// File: rtl/decode_queue.sv
// decode_queue: registered decode FIFO that classifies fetched instructions on their way to execute
// Ports: clk, reset (synchronous, active-high, wins over flush); flush drops queued and offered entries;
//    in_valid/in_ready/in_pc/in_instr fetch side; out_valid/out_ready/out_pc/out_instr/out_class/out_ri
//    head entry; count is the current occupancy.
// Build option: define DECODE_COP0_EN to classify MFC0/MTC0/ERET as COP0 (class 4); otherwise opcode 0x10 is RI.
module decode_queue #(
   parameter int DEPTH    = 4,
   parameter int PC_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_WIDTH-1:0]        in_pc,
   input  logic [31:0]                in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic [31:0]                out_instr,
   output logic [2:0]                 out_class,
   output logic                       out_ri,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [PC_WIDTH-1:0] r_pc    [DEPTH];
   logic [31:0]         r_instr [DEPTH];
   logic [2:0]          r_class [DEPTH];
   logic [PW-1:0]       r_head, r_tail;
   logic [CW-1:0]       r_count;
   logic                w_push, w_pop;
   logic [2:0]          w_class;
   logic [5:0]          w_op;
   logic [4:0]          w_rt;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   assign w_op      = in_instr[31:26];
   assign w_rt      = in_instr[20:16];
   // in_ready looks only at occupancy, so a full queue refuses a push even while popping
   assign in_ready  = r_count != CW'(DEPTH);
   assign out_valid = r_count != '0;
   assign w_push    = in_valid & in_ready & ~flush;
   assign w_pop     = out_valid & out_ready & ~flush;
   assign count     = r_count;
   assign out_pc    = r_pc[r_head];
   assign out_instr = r_instr[r_head];
   assign out_class = r_class[r_head];
   assign out_ri    = out_class == 3'd7;

   always_comb begin
      w_class = 3'd7;
      case (w_op)
         6'h00: w_class = 3'd0;
         6'h01: w_class = (w_rt == 5'h00 || w_rt == 5'h01 || w_rt == 5'h10 || w_rt == 5'h11) ? 3'd1 : 3'd7;
         6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: w_class = 3'd1;
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: w_class = 3'd2;
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: w_class = 3'd3;
`ifdef DECODE_COP0_EN
         6'h10: w_class = (in_instr[25:21] == 5'h00 || in_instr[25:21] == 5'h04 ||
                           (in_instr[25:21] == 5'h10 && in_instr[5:0] == 6'h18)) ? 3'd4 : 3'd7;
`endif
         default: w_class = 3'd7;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc[r_tail]    <= in_pc;
         r_instr[r_tail] <= in_instr;
         r_class[r_tail] <= w_class;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= nxt(r_tail);
         if (w_pop) r_head <= nxt(r_head);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, parametrised decode stage between fetch and execute in the refcpu.
- Buffers up to DEPTH fetched {pc, instr} pairs in a circular queue.
- Classifies each instruction at enqueue time into an execution class, with the reserved-instruction (RI) flag stored alongside it.
- Valid/ready handshakes on both sides; flush support for redirects and exceptions.

Parameters:
- DEPTH, 4, number of queue entries; any integer >= 2; non-power-of-2 allowed.
- PC_WIDTH, 32, width of the pc field carried with each instruction.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all queued and incoming entries this cycle
- in_valid  input  1  fetch offers an instruction
- in_ready  output  1  queue can accept; equals (count != DEPTH)
- in_pc  input  PC_WIDTH  pc of offered instruction
- in_instr  input  32  offered instruction word
- out_valid  output  1  head entry present; equals (count != 0)
- out_ready  input  1  consumer accepts head entry
- out_pc  output  PC_WIDTH  head pc
- out_instr  output  32  head instruction word
- out_class  output  3  head class: 0 RTYPE, 1 BRANCH, 2 ARITH, 3 MEM, 4 COP0, 7 RI
- out_ri  output  1  head is a reserved instruction; equals (out_class == 7)
- count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Push = in_valid & in_ready & !flush.
- Pop = out_valid & out_ready & !flush.
- Reset: count=0, head/tail pointers=0, out_valid=0, in_ready=1. out_pc, out_instr and out_class are don't-care while out_valid=0.
- Latency: an entry pushed in cycle N is visible at the head (out_valid=1) in cycle N+1 at the earliest. There is no combinational in->out bypass.
- in_ready depends only on count, never on out_ready. A full queue refuses a push even in a cycle with a simultaneous pop.
- Simultaneous push and pop on a non-empty, non-full queue: count unchanged, both pointers advance.
- Pointers wrap from DEPTH-1 to 0.
- Head outputs stay stable while out_valid=1 and out_ready=0.
- Flush, including mid-stream: at the next edge count=0 and pointers=0. Flush takes priority over push and pop; any offered in_valid that cycle is dropped. out_valid=0 in the following cycle.
- reset has priority over flush.
- Classification is done combinationally on in_instr[31:26] and stored per entry:
  - 0x00 -> RTYPE.
  - 0x02, 0x03, 0x04..0x07 -> BRANCH.
  - 0x01 (REGIMM) -> BRANCH only if rt (bits 20:16) is one of 0x00, 0x01, 0x10, 0x11; any other rt -> RI.
  - 0x08..0x0F -> ARITH.
  - 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B -> MEM.
  - 0x10 -> see Optional Feature.
  - All other opcodes -> RI.
- RI entries are queued and handed on like any other entry; the queue never stalls on RI.

Optional Feature:
- Macro: DECODE_COP0_EN.
- Defined: opcode 0x10 classifies as COP0 (4), but only when rs (bits 25:21) is 0x00 (MFC0), 0x04 (MTC0), or 0x10 with funct 0x18 (ERET). Any other 0x10 encoding -> RI.
- Undefined: opcode 0x10 always classifies as RI, and class 4 is never produced.

Test Plan:
- Reset, then push ADDIU 0x24010005 at pc 0xBFC00000, out_ready=1 -> out_valid rises exactly one cycle later with out_class=2 and out_pc=0xBFC00000; count goes 1 then 0.
- out_ready=0, push 5 instructions with DEPTH=4 -> in_ready=0 after the 4th push; the 5th is held by fetch; count=4; draining returns the entries in FIFO order across pointer wrap.
- Full queue with in_valid=1 and out_ready=1 in the same cycle -> pop only, count 4->3; in_ready=1 the next cycle.
- REGIMM 0x04110010 (rt=0x11) -> class 1; 0x04050000 (rt=0x05) -> class 7 with out_ri=1; opcode 0x3F -> class 7.
- Queue holding 3 entries, flush=1 together with in_valid=1 -> next cycle count=0 and out_valid=0; the offered entry never appears.
- 0x40826000 (MTC0): with DECODE_COP0_EN -> class 4; without DECODE_COP0_EN -> class 7.
